// File: rtl/matrix_stim_gen.sv
// matrix_stim_gen
//   Drives a programmed bit sequence onto one selected fabric pin, holding
//   each symbol for HOLD cycles, and on the last cycle of every symbol
//   compares one selected observation pin against the programmed expected
//   bit, counting mismatches (saturating).
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   pat_we/addr/wdata     : pattern memory write ({exp, stim} per symbol)
//   len, pin_sel, obs_sel, loop : run setup, latched on an accepted start
//   start, stop           : one-cycle run / abort requests
//   obs                   : fabric pin readback
//   drv, drv_oe           : pin drive value / one-hot enable while running
//   busy, done            : running flag / completion pulse
//   err_cnt, step_idx     : mismatch count / current symbol index
module matrix_stim_gen #(
    parameter int NPIN  = 4,
    parameter int NOBS  = 5,
    parameter int DEPTH = 32,
    parameter int HOLD  = 30,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pat_we,
    input  logic [AW-1:0]           pat_addr,
    input  logic [1:0]              pat_wdata,
    input  logic [AW:0]             len,
    input  logic [$clog2(NPIN)-1:0] pin_sel,
    input  logic [$clog2(NOBS)-1:0] obs_sel,
    input  logic                    loop,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NOBS-1:0]         obs,
    output logic [NPIN-1:0]         drv,
    output logic [NPIN-1:0]         drv_oe,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_cnt,
    output logic [AW-1:0]           step_idx
);
    localparam int HW = $clog2(HOLD);
    localparam int PW = $clog2(NPIN);
    localparam int OW = $clog2(NOBS);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t state_q, state_d;

    // Pattern memory: not reset, so a program survives rst_n.
    logic [1:0] mem [DEPTH];

    logic [AW:0]   len_q;
    logic [PW-1:0] pin_q;
    logic [OW-1:0] obs_q;
    logic          loop_q;
    logic [HW-1:0] hold_q;
    // Current symbol {exp, stim}. Loaded when the symbol starts, so symbol 0
    // is captured on the start edge before a same-cycle write lands.
    logic [1:0]    cur_q;

    logic          start_ok, last_cyc, last_sym;
    logic          load, sample, adv;
    logic [AW-1:0] nxt_idx;
    logic [NPIN-1:0] pin_oh;

    assign start_ok = start && (len != '0) && (len <= (AW+1)'(DEPTH));
    assign last_cyc = (hold_q == HW'(HOLD - 1));
    assign last_sym = ({1'b0, step_idx} == len_q - 1'b1);
    assign nxt_idx  = last_sym ? '0 : step_idx + 1'b1;
    assign pin_oh   = NPIN'(1) << pin_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sample  = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = DRIVE;
                load    = 1'b1;
            end
            DRIVE: begin
                // stop wins over a sample on the same edge
                if (stop) begin
                    state_d = IDLE;
                end else if (last_cyc) begin
                    sample = 1'b1;
                    if (!last_sym || loop_q) adv = 1'b1;
                    else                     state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pat_we && state_q != DRIVE) mem[pat_addr] <= pat_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q    <= '0;
            pin_q    <= '0;
            obs_q    <= '0;
            loop_q   <= 1'b0;
            hold_q   <= '0;
            cur_q    <= '0;
            err_cnt  <= '0;
            step_idx <= '0;
        end else if (load) begin
            len_q    <= len;
            pin_q    <= pin_sel;
            obs_q    <= obs_sel;
            loop_q   <= loop;
            hold_q   <= '0;
            cur_q    <= mem[0];
            err_cnt  <= '0;
            step_idx <= '0;
        end else if (state_q == DRIVE && !stop) begin
            hold_q <= last_cyc ? '0 : hold_q + 1'b1;
            if (sample && (obs[obs_q] != cur_q[1]) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
            if (adv) begin
                step_idx <= nxt_idx;
                cur_q    <= mem[nxt_idx];
            end
        end
    end

    assign busy   = (state_q == DRIVE);
    assign done   = (state_q == DONE);
    assign drv_oe = busy ? pin_oh : '0;
    assign drv    = (busy && cur_q[0]) ? pin_oh : '0;
endmodule
